// File: rtl/v_ram_responder_pkg.sv
// v_ram_responder_pkg: shared vector-unit types, default widths and a saturating-counter helper.
// Provides the VRAM_DW/VRAM_AW defaults, the error-counter width/type and the memory-access defaults.
package v_ram_responder_pkg;
  localparam int VRAM_DW_DEF = 256;
  localparam int VRAM_AW_DEF = 32;
  localparam int DEPTH_DEF = 1024;
  localparam int RD_LAT_DEF = 1;
  localparam int ERR_CNT_W = 16;
  typedef logic [ERR_CNT_W-1:0] err_cnt_t;
  function automatic err_cnt_t sat_inc(input err_cnt_t v);
    return &v ? v : v + err_cnt_t'(1);
  endfunction
endpackage

// File: rtl/v_ram_rd_pipe.sv
// v_ram_rd_pipe: LAT-deep read-return shift register (valid plus data).
// Ports: clk/rst (async, active-high); vld_i/dat_i enter stage 0; vld_o/dat_o leave the last stage.
// Each stage's data only loads when a valid enters it, so dat_o holds the last returned read.
module v_ram_rd_pipe #(
  parameter int DW = 256,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  output logic          vld_o,
  output logic [DW-1:0] dat_o
);
  logic [LAT-1:0] vld_q, vld_d;
  logic [DW-1:0] dat_q [LAT];
  logic [DW-1:0] dat_d [LAT];
  always_comb begin
    vld_d = LAT'({vld_q, vld_i});
    dat_d[0] = vld_i ? dat_i : dat_q[0];
    for (int i = 1; i < LAT; i++) dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end
  assign vld_o = vld_q[LAT-1];
  assign dat_o = dat_q[LAT-1];
endmodule

// File: rtl/v_ram_responder.sv
// v_ram_responder: bit-masked VRAM model with fixed read latency and out-of-range error tracking.
// Ports: clk/rst (async, active-high); vram_ren_i/vram_wen_i/vram_addr_i/vram_mask_i/vram_din_i request;
// vram_dout_o/vram_rvalid_o read return; vram_err_o sticky error; vram_err_cnt_o saturating error count.
module v_ram_responder import v_ram_responder_pkg::*; #(
  parameter int VRAM_DW = VRAM_DW_DEF,
  parameter int VRAM_AW = VRAM_AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vram_ren_i,
  input  logic               vram_wen_i,
  input  logic [VRAM_AW-1:0] vram_addr_i,
  input  logic [VRAM_DW-1:0] vram_mask_i,
  input  logic [VRAM_DW-1:0] vram_din_i,
  output logic [VRAM_DW-1:0] vram_dout_o,
  output logic               vram_rvalid_o,
  output logic               vram_err_o,
  output err_cnt_t           vram_err_cnt_o
);
  localparam int OFS = $clog2(VRAM_DW / 8);
  localparam int IW = $clog2(DEPTH);
  logic [VRAM_DW-1:0] mem [DEPTH];
  logic [IW-1:0] idx;
  logic oor, bad, wr;
  logic [VRAM_DW-1:0] rd_dat;
  logic err_q, err_d;
  err_cnt_t cnt_q, cnt_d;
  always_comb begin
    idx = vram_addr_i[OFS +: IW];
    oor = |(vram_addr_i >> (OFS + IW));
    bad = (vram_ren_i | vram_wen_i) & oor;
    wr = vram_wen_i & ~oor & ~rst;
    // old contents are sampled by the first pipe stage on the same edge as the write: read-before-write
    rd_dat = oor ? '0 : mem[idx];
    err_d = err_q | bad;
    cnt_d = bad ? sat_inc(cnt_q) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (wr) mem[idx] <= (mem[idx] & ~vram_mask_i) | (vram_din_i & vram_mask_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  v_ram_rd_pipe #(.DW(VRAM_DW), .LAT(RD_LAT)) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (vram_ren_i),
    .dat_i (rd_dat),
    .vld_o (vram_rvalid_o),
    .dat_o (vram_dout_o)
  );
  assign vram_err_o = err_q;
  assign vram_err_cnt_o = cnt_q;
endmodule

// File: tb/tb_v_ram_responder.sv
// tb_v_ram_responder: checks three responders (RD_LAT 1,2,3) sharing one request stream against a reference model.
module tb_v_ram_responder;
  localparam int DW = 256;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ren = 1'b0;
  logic wen = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] mask = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout_w [3];
  logic rv_w [3];
  logic err_w [3];
  logic [15:0] cnt_w [3];
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mem_m [int];
  logic hv [$];
  logic [DW-1:0] hd [$];
  logic [DW-1:0] exp_d [3];
  logic exp_v [3];
  logic exp_err = 1'b0;
  int exp_cnt = 0;
  localparam logic [DW-1:0] HALF_HI = {{128{1'b1}}, {128{1'b0}}};
  localparam logic [DW-1:0] HALF_LO = {{128{1'b0}}, {128{1'b1}}};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    v_ram_responder #(.RD_LAT(g + 1)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .vram_ren_i     (ren),
      .vram_wen_i     (wen),
      .vram_addr_i    (addr),
      .vram_mask_i    (mask),
      .vram_din_i     (din),
      .vram_dout_o    (dout_w[g]),
      .vram_rvalid_o  (rv_w[g]),
      .vram_err_o     (err_w[g]),
      .vram_err_cnt_o (cnt_w[g])
    );
  end
  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  // drive one request, advance one clock, update the model, return just after the falling edge
  task automatic step(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] m, input logic [DW-1:0] d);
    logic oor;
    int idx;
    logic [DW-1:0] old;
    ren = r; wen = w; addr = a; mask = m; din = d;
    @(posedge clk);
    oor = |a[AW-1:15];
    idx = int'(a[14:5]);
    old = mem_m.exists(idx) ? mem_m[idx] : '0;
    if (rst) begin
      hv.delete(); hd.delete();
      exp_err = 1'b0; exp_cnt = 0;
      for (int i = 0; i < 3; i++) exp_d[i] = '0;
    end else begin
      hv.push_back(r);
      hd.push_back(oor ? '0 : old);
      if ((r || w) && oor) begin
        exp_err = 1'b1;
        if (exp_cnt < 65535) exp_cnt++;
      end
      if (w && !oor) mem_m[idx] = (old & ~m) | (d & m);
    end
    for (int i = 0; i < 3; i++) begin
      exp_v[i] = (hv.size() > i) && hv[hv.size() - 1 - i];
      if (exp_v[i]) exp_d[i] = hd[hv.size() - 1 - i];
    end
    @(negedge clk);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 32'h0000_8000, '1, '1);
    step(1'b1, 1'b0, 32'h0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (rv_w[i] !== 1'b0) begin failures++; $display("FAIL reset_rvalid dut%0d got=%b exp=0", i, rv_w[i]); end
      checks++; if (dout_w[i] !== '0) begin failures++; $display("FAIL reset_dout dut%0d got=%h exp=0", i, dout_w[i]); end
      checks++; if (err_w[i] !== 1'b0) begin failures++; $display("FAIL reset_err dut%0d got=%b exp=0", i, err_w[i]); end
      checks++; if (cnt_w[i] !== 16'd0) begin failures++; $display("FAIL reset_cnt dut%0d got=%0d exp=0", i, cnt_w[i]); end
    end
    rst = 1'b0;
  endtask
  task automatic test_masked_write();
    step(1'b0, 1'b1, 32'h0, '1, '1);
    step(1'b0, 1'b1, 32'h0, HALF_LO, '0);
    step(1'b1, 1'b0, 32'h1f, '0, '0);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (rv_w[s] !== 1'b1 || dout_w[s] !== HALF_HI) begin
        failures++; $display("FAIL masked_write dut%0d rvalid=%b got=%h exp=%h", s, rv_w[s], dout_w[s], HALF_HI);
      end
      idle();
    end
  endtask
  task automatic test_latency();
    logic [DW-1:0] v [3];
    int j;
    for (int k = 0; k < 3; k++) begin
      v[k] = rnd();
      step(1'b0, 1'b1, AW'((k + 1) * 32), '1, v[k]);
    end
    for (int s = 0; s < 6; s++) begin
      if (s < 3) step(1'b1, 1'b0, AW'((s + 1) * 32), '0, '0);
      else idle();
      for (int i = 0; i < 3; i++) begin
        j = s - i;
        checks++;
        if (rv_w[i] !== (j >= 0 && j < 3)) begin
          failures++; $display("FAIL latency_rvalid dut%0d cyc=%0d got=%b exp=%b", i, s, rv_w[i], (j >= 0 && j < 3));
        end
        if (j >= 0) begin
          checks++;
          if (dout_w[i] !== v[j > 2 ? 2 : j]) begin
            failures++; $display("FAIL latency_data dut%0d cyc=%0d got=%h exp=%h", i, s, dout_w[i], v[j > 2 ? 2 : j]);
          end
        end
      end
    end
  endtask
  task automatic test_read_before_write();
    step(1'b0, 1'b1, 32'h20, '1, {32{8'hA5}});
    step(1'b1, 1'b1, 32'h20, '1, {32{8'h5A}});
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (rv_w[s] !== 1'b1 || dout_w[s] !== {32{8'hA5}}) begin
        failures++; $display("FAIL rbw_old dut%0d rvalid=%b got=%h exp=%h", s, rv_w[s], dout_w[s], {32{8'hA5}});
      end
      idle();
    end
    step(1'b1, 1'b0, 32'h20, '0, '0);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (rv_w[s] !== 1'b1 || dout_w[s] !== {32{8'h5A}}) begin
        failures++; $display("FAIL rbw_new dut%0d rvalid=%b got=%h exp=%h", s, rv_w[s], dout_w[s], {32{8'h5A}});
      end
      idle();
    end
  endtask
  task automatic test_out_of_range();
    step(1'b1, 1'b0, 32'h8000, '0, '0);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (rv_w[s] !== 1'b1 || dout_w[s] !== '0) begin
        failures++; $display("FAIL oor_read dut%0d rvalid=%b got=%h exp=0", s, rv_w[s], dout_w[s]);
      end
      checks++;
      if (err_w[s] !== 1'b1 || cnt_w[s] !== 16'd1) begin
        failures++; $display("FAIL oor_cnt1 dut%0d err=%b cnt=%0d exp err=1 cnt=1", s, err_w[s], cnt_w[s]);
      end
      idle();
    end
    step(1'b0, 1'b1, 32'h8000, '1, '1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt_w[i] !== 16'd2) begin failures++; $display("FAIL oor_cnt2 dut%0d got=%0d exp=2", i, cnt_w[i]); end
    end
    step(1'b1, 1'b0, 32'h0, '0, '0);
    checks++;
    if (rv_w[0] !== 1'b1 || dout_w[0] !== HALF_HI) begin
      failures++; $display("FAIL oor_mem_unchanged rvalid=%b got=%h exp=%h", rv_w[0], dout_w[0], HALF_HI);
    end
    step(1'b1, 1'b1, 32'hFFFF_FFE0, '1, '1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt_w[i] !== 16'd3 || err_w[i] !== 1'b1) begin
        failures++; $display("FAIL oor_rw_once dut%0d err=%b cnt=%0d exp err=1 cnt=3", i, err_w[i], cnt_w[i]);
      end
    end
    repeat (3) idle();
  endtask
  task automatic test_reset_mid_read();
    step(1'b1, 1'b0, 32'h20, '0, '0);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (err_w[i] !== 1'b0 || cnt_w[i] !== 16'd0 || rv_w[i] !== 1'b0) begin
        failures++; $display("FAIL async_reset dut%0d err=%b cnt=%0d rvalid=%b exp all 0", i, err_w[i], cnt_w[i], rv_w[i]);
      end
    end
    idle();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      idle();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rv_w[i] !== 1'b0 || dout_w[i] !== '0 || err_w[i] !== 1'b0 || cnt_w[i] !== 16'd0) begin
          failures++; $display("FAIL reset_mid_read dut%0d cyc=%0d rvalid=%b dout=%h err=%b cnt=%0d exp all 0", i, s, rv_w[i], dout_w[i], err_w[i], cnt_w[i]);
        end
      end
    end
  endtask
  task automatic test_random();
    logic r, w;
    logic [AW-1:0] a;
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, AW'(k * 32), '1, rnd());
    for (int n = 0; n < 300; n++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        a[15] = 1'b1;
      end else a = (AW'($urandom_range(0, 15)) << 5) | AW'($urandom_range(0, 31));
      step(r, w, a, $urandom_range(0, 1) ? '1 : rnd(), rnd());
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rv_w[i] !== exp_v[i] || dout_w[i] !== exp_d[i]) begin
          failures++; $display("FAIL random_read dut%0d n=%0d rvalid=%b dout=%h exp rvalid=%b dout=%h", i, n, rv_w[i], dout_w[i], exp_v[i], exp_d[i]);
        end
        checks++;
        if (err_w[i] !== exp_err || cnt_w[i] !== 16'(exp_cnt)) begin
          failures++; $display("FAIL random_err dut%0d n=%0d err=%b cnt=%0d exp err=%b cnt=%0d", i, n, err_w[i], cnt_w[i], exp_err, exp_cnt);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_masked_write();
    test_latency();
    test_read_before_write();
    test_out_of_range();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/v_ram_responder.md
V_RAM_RESPONDER -- requirements
Module: v_ram_responder

Interface
REQ-001 SHALL have parameter VRAM_DW, default 256, data/mask width in bits (multiple of 8, power of two).
REQ-002 SHALL have parameter VRAM_AW, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of VRAM_DW-bit words (power of two).
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles, legal range 1..4.
REQ-005 SHALL have port clk, input, 1, the only clock, all state on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port vram_ren_i, input, 1, read request this cycle.
REQ-008 SHALL have port vram_wen_i, input, 1, write request this cycle.
REQ-009 SHALL have port vram_addr_i, input, VRAM_AW, byte address.
REQ-010 SHALL have port vram_mask_i, input, VRAM_DW, bit-level write enable.
REQ-011 SHALL have port vram_din_i, input, VRAM_DW, write data.
REQ-012 SHALL have port vram_dout_o, output, VRAM_DW, read data.
REQ-013 SHALL have port vram_rvalid_o, output, 1, vram_dout_o holds a returned read.
REQ-014 SHALL have port vram_err_o, output, 1, sticky out-of-range flag.
REQ-015 SHALL have port vram_err_cnt_o, output, 16, count of out-of-range requests.

Function
REQ-016 SHALL form word index from addr bits [OFS +: log2(DEPTH)], with OFS = log2(VRAM_DW/8); low OFS bits ignored.
REQ-017 SHALL treat a request as out-of-range when any addr bit at or above OFS+log2(DEPTH) is 1.
REQ-018 SHALL perform a write on a rising edge with vram_wen_i=1 and address in range, as mem[idx] = (mem[idx] & ~mask) | (din & mask).
REQ-019 SHALL accept one request per cycle with no back-pressure; no ready signal exists.
REQ-020 SHALL return a read issued in cycle N on vram_dout_o with vram_rvalid_o=1 in cycle N+RD_LAT, for one cycle.
REQ-021 SHALL hold vram_dout_o at its last value while vram_rvalid_o=0.
REQ-022 SHALL, when ren and wen are both 1 to the same word, return the pre-write contents (read-before-write).
REQ-023 SHALL return the latest write for a read issued one or more cycles after that write, with no RD_LAT hazard.
REQ-024 SHALL, for an out-of-range read, still assert vram_rvalid_o at N+RD_LAT, with vram_dout_o all zeros.
REQ-025 SHALL ignore an out-of-range write, with memory unchanged.
REQ-026 SHALL, on any out-of-range request (ren or wen), set vram_err_o and increment vram_err_cnt_o by 1 (a simultaneous ren+wen counts 1), saturating at 16'hFFFF.
REQ-027 SHALL pipeline back-to-back reads fully: RD_LAT reads in flight, returned in issue order.

Reset
REQ-028 SHALL asynchronously clear, while rst=1: vram_dout_o=0, vram_rvalid_o=0, vram_err_o=0, vram_err_cnt_o=0, and all in-flight pipeline valids.
REQ-029 SHALL discard any read in flight when rst asserts, with no vram_rvalid_o after rst deasserts.
REQ-030 SHALL neither reset nor initialise memory contents.
REQ-031 SHALL ignore requests in cycles where rst=1.

Structure
REQ-032 SHALL take VRAM_DW/VRAM_AW defaults and the error-counter width from the shared vector-unit package, alongside the memory-access parameters.
REQ-033 SHALL implement the read-latency shift register (valid plus data, depth RD_LAT) as sub-module v_ram_rd_pipe.
REQ-034 SHALL keep the storage array in the top module, inferable as single-port synchronous RAM with a bit-write mask.

Verification
REQ-035 SHALL verify masked write: write word 0 all-ones full mask, then din=0 with mask low 128 bits -> read addr 0 returns upper 128 ones, lower 128 zeros.
REQ-036 SHALL verify latency: RD_LAT=3, reads of addr 0x20,0x40,0x60 on consecutive cycles -> rvalid on cycles N+3..N+5 with the matching data in order.
REQ-037 SHALL verify read-before-write: mem[1]=A5..A5, same-cycle read+write 5A..5A to addr 0x20 -> dout=A5..A5, next read 5A..5A.
REQ-038 SHALL verify out-of-range: DEPTH=1024, read at 0x8000 -> rvalid with dout=0, err=1, cnt=1; write there -> cnt=2, memory unchanged.
REQ-039 SHALL verify reset mid-read: rst pulse one cycle after a read with RD_LAT=2 -> no rvalid afterward, dout=0, err/cnt=0.
